// File: rtl/circuito_jogo_sequencia_param.sv
// Sequence-memory game: loadable DEPTH x WIDTH memory, edge-detected plays,
// progressive rounds and per-play timeout, with 7-segment debug outputs.
module circuito_jogo_sequencia_param #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 5000,
    localparam int ADDR   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             modo,
    input  logic             jogar,
    input  logic [WIDTH-1:0] chaves,
    input  logic             escreve,
    input  logic [ADDR-1:0]  endereco_carga,
    input  logic [WIDTH-1:0] dado_carga,
    output logic             pronto,
    output logic             acertou,
    output logic             errou,
    output logic             timeout,
    output logic [6:0]       db_estado,
    output logic [6:0]       db_contagem,
    output logic [6:0]       db_rodada,
    output logic [6:0]       db_memoria,
    output logic [6:0]       db_jogada
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [ADDR-1:0] LAST  = ADDR'(DEPTH - 1);
    localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARA     = 4'h4,
        PROXIMO     = 4'h5,
        PROX_RODADA = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hD
    } estado_t;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    estado_t          estado;
    logic [ADDR-1:0]  addr;
    logic [ADDR-1:0]  rodada;
    logic [ADDR-1:0]  lim;
    logic [TW-1:0]    tcnt;
    logic [WIDTH-1:0] jogada;
    logic [WIDTH-1:0] dado_mem;
    logic             jogar_q;
    logic             modo_q;
    logic             borda;

    logic [WIDTH-1:0] mem [DEPTH];

    assign borda    = jogar & ~jogar_q;
    assign lim      = modo_q ? rodada : LAST;
    assign dado_mem = mem[addr];

    // No reset on the array: contents must survive a board reset.
    always_ff @(posedge clock) begin
        if (escreve && estado == INICIAL)
            mem[endereco_carga] <= dado_carga;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado  <= INICIAL;
            addr    <= '0;
            rodada  <= '0;
            tcnt    <= '0;
            jogada  <= '0;
            jogar_q <= 1'b0;
            modo_q  <= 1'b0;
        end else begin
            jogar_q <= jogar;
            case (estado)
                INICIAL: begin
                    if (iniciar) estado <= PREPARA;
                end
                PREPARA: begin
                    addr   <= '0;
                    rodada <= '0;
                    tcnt   <= '0;
                    jogada <= '0;
                    modo_q <= modo;
                    estado <= ESPERA;
                end
                ESPERA: begin
                    if (borda)
                        estado <= REGISTRA;
                    else if (tcnt == TLAST)
                        estado <= FIM_TIMEOUT;
                    else
                        tcnt <= tcnt + 1'b1;
                end
                REGISTRA: begin
                    jogada <= chaves;
                    tcnt   <= '0;
                    estado <= COMPARA;
                end
                COMPARA: begin
                    if (jogada != dado_mem)
                        estado <= FIM_ERRO;
                    else if (addr < lim)
                        estado <= PROXIMO;
                    else if (lim == LAST)
                        estado <= FIM_ACERTO;
                    else
                        estado <= PROX_RODADA;
                end
                PROXIMO: begin
                    addr   <= addr + 1'b1;
                    estado <= ESPERA;
                end
                PROX_RODADA: begin
                    rodada <= rodada + 1'b1;
                    addr   <= '0;
                    tcnt   <= '0;
                    estado <= ESPERA;
                end
                FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                    if (iniciar) estado <= PREPARA;
                end
                default: estado <= INICIAL;
            endcase
        end
    end

    assign pronto  = (estado == FIM_ACERTO) || (estado == FIM_ERRO) ||
                     (estado == FIM_TIMEOUT);
    assign acertou = (estado == FIM_ACERTO);
    assign errou   = (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
    assign timeout = (estado == FIM_TIMEOUT);

    // Debug nibbles are zero-extended when the source is narrower than 4 bits.
    logic [3:0] addr_n, rod_n, mem_n, jog_n;

    if (ADDR >= 4) begin : g_addr_wide
        assign addr_n = addr[3:0];
        assign rod_n  = rodada[3:0];
    end else begin : g_addr_narrow
        assign addr_n = 4'(addr);
        assign rod_n  = 4'(rodada);
    end

    if (WIDTH >= 4) begin : g_data_wide
        assign mem_n = dado_mem[3:0];
        assign jog_n = jogada[3:0];
    end else begin : g_data_narrow
        assign mem_n = 4'(dado_mem);
        assign jog_n = 4'(jogada);
    end

    assign db_estado   = hex7(estado);
    assign db_contagem = hex7(addr_n);
    assign db_rodada   = hex7(rod_n);
    assign db_memoria  = hex7(mem_n);
    assign db_jogada   = hex7(jog_n);

endmodule

// File: tb/tb_circuito_jogo_sequencia_param.sv
// Scoreboard bench: a driver pushes predicted game outcomes, a monitor pops
// them when pronto rises and compares against the DUT.
module tb_circuito_jogo_sequencia_param;

    localparam int W = 4;
    localparam int D = 4;
    localparam int T = 20;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         iniciar = 1'b0;
    logic         modo = 1'b0;
    logic         jogar = 1'b0;
    logic [W-1:0] chaves = '0;
    logic         escreve = 1'b0;
    logic [1:0]   endereco_carga = '0;
    logic [W-1:0] dado_carga = '0;
    logic         pronto, acertou, errou, timeout;
    logic [6:0]   db_estado, db_contagem, db_rodada, db_memoria, db_jogada;

    circuito_jogo_sequencia_param #(
        .WIDTH(W), .DEPTH(D), .TIMEOUT(T)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo),
        .jogar(jogar), .chaves(chaves), .escreve(escreve),
        .endereco_carga(endereco_carga), .dado_carga(dado_carga),
        .pronto(pronto), .acertou(acertou), .errou(errou),
        .timeout(timeout), .db_estado(db_estado),
        .db_contagem(db_contagem), .db_rodada(db_rodada),
        .db_memoria(db_memoria), .db_jogada(db_jogada)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int addr;
        int rod;
        int jog;
        int due;
    } exp_t;

    typedef struct {
        int val;
        int addr;
        int rod;
    } tag_t;

    exp_t sb[$];
    tag_t tags[$];
    int   plays[$];
    int   mem_m[D];

    function automatic logic [6:0] seg(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    // Monitor: a game end is signalled by a rising pronto.
    logic pronto_q = 1'b0;
    always @(negedge clock) begin
        if (reset && pronto && !pronto_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_end", 1, 0);
            end else begin
                exp_t e;
                int code;
                e = sb.pop_front();
                code = (e.kind == 0) ? 10 : (e.kind == 1) ? 14 : 13;
                chk("end_cycle", cyc, e.due);
                chk("acertou", int'(acertou), int'(e.kind == 0));
                chk("errou", int'(errou), int'(e.kind != 0));
                chk("timeout", int'(timeout), int'(e.kind == 2));
                chk("end_estado", db_estado, seg(code));
                chk("end_contagem", db_contagem, seg(e.addr));
                chk("end_rodada", db_rodada, seg(e.rod));
                chk("end_jogada", db_jogada, seg(e.jog));
            end
        end
        pronto_q <= pronto;
    end

    // Reference: the whole game flattened into the ordered list of
    // expected plays, each tagged with its position and round.
    task automatic build_tags(input bit m);
        tags.delete();
        if (!m) begin
            for (int i = 0; i < D; i++) tags.push_back('{mem_m[i], i, 0});
        end else begin
            for (int k = 0; k < D; k++)
                for (int i = 0; i <= k; i++)
                    tags.push_back('{mem_m[i], i, k});
        end
    endtask

    task automatic reset_and_load();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < D; i++) begin
            escreve = 1'b1;
            endereco_carga = 2'(i);
            dado_carga = 4'(mem_m[i]);
            @(negedge clock);
        end
        escreve = 1'b0;
        chk("mem0_inicial", db_memoria, seg(mem_m[0]));
    endtask

    task automatic start_game(input bit m, output int e_cyc);
        @(negedge clock);
        iniciar = 1'b1;
        modo = m;
        @(negedge clock);
        iniciar = 1'b0;
        chk("prepara_estado", db_estado, seg(1));
        chk("prepara_flags", int'({pronto, acertou, errou, timeout}), 0);
        @(negedge clock);
        chk("espera_estado", db_estado, seg(2));
        e_cyc = cyc;
    endtask

    task automatic run_game(input bit m, input int hold_mask,
                            input int glitch_mask, input int write_mask,
                            input int late_mask);
        int n, used, kind, j, jog, e_cyc, p_cyc;
        tag_t t;
        exp_t e;
        build_tags(m);
        n = plays.size();
        j = -1;
        for (int i = 0; i < n; i++)
            if (j < 0 && i < tags.size() && plays[i] != tags[i].val) j = i;
        if (j >= 0) begin
            kind = 1; t = tags[j]; used = j + 1; jog = plays[j];
        end else if (n < tags.size()) begin
            kind = 2; t = tags[n]; used = n;
            jog = (n > 0) ? plays[n-1] : 0;
        end else begin
            kind = 0; t = tags[tags.size()-1]; used = n; jog = plays[n-1];
        end
        start_game(m, e_cyc);
        for (int p = 0; p < used; p++) begin
            if (write_mask[p]) begin
                escreve = 1'b1;
                endereco_carga = 2'($urandom_range(0, 3));
                dado_carga = 4'($urandom_range(0, 15));
                @(negedge clock);
                escreve = 1'b0;
            end
            if (late_mask[p])
                while (cyc < e_cyc + T - 1) @(negedge clock);
            else
                repeat ($urandom_range(0, 2)) @(negedge clock);
            chk("mem_read", db_memoria, seg(mem_m[tags[p].addr]));
            p_cyc = cyc;
            if (p == used - 1 && kind != 2) begin
                e = '{kind, t.addr, t.rod, jog, p_cyc + 3};
                sb.push_back(e);
            end
            chaves = 4'(plays[p]);
            jogar = 1'b1;
            if (hold_mask[p]) begin
                repeat (10) @(negedge clock);
                jogar = 1'b0;
                @(negedge clock);
            end else begin
                @(negedge clock);
                jogar = 1'b0;
                @(negedge clock);
                jogar = glitch_mask[p];
                @(negedge clock);
                jogar = 1'b0;
                @(negedge clock);
            end
            e_cyc = p_cyc + 4;
        end
        if (kind == 2) begin
            e = '{kind, t.addr, t.rod, jog, e_cyc + T};
            sb.push_back(e);
        end
        while (cyc < e.due + 2) @(negedge clock);
        chk("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int e_cyc;
        bit m;
        int len, v;

        repeat (3) @(negedge clock);
        #1;
        chk("rst_estado", db_estado, seg(0));
        chk("rst_flags", int'({pronto, acertou, errou, timeout}), 0);
        chk("rst_contagem", db_contagem, seg(0));
        chk("rst_rodada", db_rodada, seg(0));
        chk("rst_jogada", db_jogada, seg(0));

        mem_m = '{1, 2, 4, 8};
        reset_and_load();

        // Reset while the first play is being compared.
        start_game(1'b0, e_cyc);
        chaves = 4'd1;
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_estado", db_estado, seg(0));
        chk("midrst_flags", int'({pronto, acertou, errou, timeout}), 0);
        chk("midrst_jogada", db_jogada, seg(0));
        chk("midrst_contagem", db_contagem, seg(0));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mem_kept", db_memoria, seg(1));

        plays = '{1, 2, 4, 8};
        run_game(1'b0, 0, 0, 0, 0);
        plays = '{1, 2, 5};
        run_game(1'b0, 0, 0, 0, 0);
        plays = '{1, 1, 2, 1, 2, 4, 1, 2, 4, 8};
        run_game(1'b1, 0, 0, 0, 0);
        plays = '{1, 1, 3};
        run_game(1'b1, 0, 0, 0, 0);
        plays = {};
        run_game(1'b0, 0, 0, 0, 0);
        plays = '{1, 1};
        run_game(1'b1, 0, 0, 0, 0);
        plays = '{1, 2, 4, 8};
        run_game(1'b0, 0, 0, 0, 'b0111);
        plays = '{1, 2, 4, 8};
        run_game(1'b0, 'b0001, 'b0010, 'b0100, 0);

        repeat (12) begin
            for (int i = 0; i < D; i++) mem_m[i] = $urandom_range(0, 15);
            reset_and_load();
            m = 1'($urandom_range(0, 1));
            build_tags(m);
            len = tags.size();
            if ($urandom_range(0, 3) == 0) len = $urandom_range(0, len - 1);
            plays.delete();
            for (int i = 0; i < len; i++) begin
                v = tags[i].val;
                if ($urandom_range(0, 9) == 0) v = (v + $urandom_range(1, 15)) % 16;
                plays.push_back(v);
            end
            run_game(m, 1 << $urandom_range(0, 12), $urandom_range(0, 1023),
                     $urandom_range(0, 1023), 1 << $urandom_range(0, 12));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/circuito_jogo_sequencia_param.md
# circuito_jogo_sequencia_param

Parametrised sequence-memory game datapath plus control unit, the successor to the fixed 16-entry, 4-bit sequence checker. Adds a loadable sequence memory, configurable key width and depth, a progressive-round mode where round k checks entries 0..k, edge-detected plays and a per-play timeout. It sits at board top level and drives the HEX displays through the team's existing hex-to-7-segment decoder.

## Interface

**Parameters**
- `WIDTH`, default 4: key and memory word width, 1..8.
- `DEPTH`, default 16: number of sequence entries, 2..256. `ADDR = $clog2(DEPTH)`.
- `TIMEOUT`, default 5000: wait cycles allowed per play, at least 2.

**Ports** (one clock; reset is asynchronous and active-low)
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `iniciar`, in, 1: start level, sampled in INICIAL and the FIM states.
- `modo`, in, 1: 0 = whole sequence per game; 1 = progressive rounds. Sampled in PREPARA.
- `jogar`, in, 1: play strobe. Only its rising edge counts.
- `chaves`, in, WIDTH: player's keys.
- `escreve`, in, 1: memory write enable. Honoured only in INICIAL.
- `endereco_carga`, in, ADDR: write address.
- `dado_carga`, in, WIDTH: write data.
- `pronto`, out, 1: game finished.
- `acertou`, out, 1: finished, all entries matched.
- `errou`, out, 1: finished, mismatch or timeout.
- `timeout`, out, 1: finished by timeout. `errou` is also 1 in this case.
- `db_estado`, out, 7: 7-segment code of the 4-bit state.
- `db_contagem`, out, 7: 7-segment code of `addr[3:0]`.
- `db_rodada`, out, 7: 7-segment code of `rodada[3:0]`.
- `db_memoria`, out, 7: 7-segment code of the zero-extended low nibble of `mem[addr]`.
- `db_jogada`, out, 7: 7-segment code of the zero-extended low nibble of the registered play.

## Operation

**Storage**
- Memory: DEPTH × WIDTH.
- Write is synchronous. Read is asynchronous, at `addr`.
- Memory contents survive reset; they are undefined until loaded.

**Edge detector**
- Register `jogar_q`.
- `borda = jogar & ~jogar_q`.
- `jogar` held high produces a single edge.

**States** (value shown on `db_estado`)
- **INICIAL (0)**
  - Writes are honoured here.
  - `iniciar=1` → PREPARA.
- **PREPARA (1)**
  - Sets `addr=0`, `rodada=0`, timeout counter `tcnt=0`, jogada register = 0.
  - Latches `modo`.
  - Next state: ESPERA.
- **ESPERA (2)**
  - `tcnt` increments each cycle.
  - `borda` → REGISTRA. `borda` has priority over timeout in the same cycle.
  - Else if `tcnt == TIMEOUT-1` → FIM_TIMEOUT.
- **REGISTRA (3)**
  - Jogada register ← `chaves`; `tcnt=0`.
  - Next state: COMPARA.
- **COMPARA (4)**
  - Jogada ≠ `mem[addr]` → FIM_ERRO.
  - Else, with `lim = (modo ? rodada : DEPTH-1)`:
    - `addr < lim` → PROXIMO.
    - `addr == lim` and `lim == DEPTH-1` → FIM_ACERTO.
    - `addr == lim`, otherwise → PROX_RODADA.
- **PROXIMO (5)**: `addr++` → ESPERA.
- **PROX_RODADA (6)**: `rodada++`, `addr=0`, `tcnt=0` → ESPERA.
- **FIM_ACERTO (A)**: `pronto=1`, `acertou=1`.
- **FIM_ERRO (E)**: `pronto=1`, `errou=1`.
- **FIM_TIMEOUT (D)**: `pronto=1`, `errou=1`, `timeout=1`.
- From any FIM state, `iniciar=1` → PREPARA. Outputs stay held until then.
- Unused encodings → INICIAL.

**Rules**
- Edges arriving outside ESPERA are discarded; they are not queued.
- `escreve` outside INICIAL has no effect.
- `addr` and `rodada` never exceed DEPTH-1; no wrap-around is possible.
- Status outputs are Moore decodes of the state register, so they are glitch-free.

## Timing

- Reset (`reset=0`), asynchronous:
  - state = INICIAL; `addr`, `rodada`, `tcnt`, jogada register and `jogar_q` = 0.
  - `pronto`, `acertou`, `errou`, `timeout` = 0.
  - `db_*` show the codes for 0.
- Reset mid-game aborts immediately. Memory is preserved.
- Start latency: `iniciar` sampled at edge t → PREPARA at t+1, ESPERA at t+2.
- Play latency: `jogar` rises before edge t while in ESPERA → REGISTRA at t+1, COMPARA at t+2, then next state at t+3.
  - At t+3, `pronto`/`errou`/`acertou` are visible if the game ended.
- `chaves` must be stable at edge t+1, the one that captures the play.
- Timeout:
  - Exactly TIMEOUT cycles spent in ESPERA without an edge → FIM_TIMEOUT.
  - The counter restarts on every REGISTRA and PROX_RODADA.
- Minimum spacing between accepted plays: 4 cycles.

## Test plan

Use `WIDTH=4`, `DEPTH=4`, `TIMEOUT=20`. Load `mem = {1,2,4,8}` in INICIAL.

1. Reset asserted mid-COMPARA → same cycle: `db_estado`=0 and all status outputs 0. After restart, `mem` still reads `{1,2,4,8}`.
2. `modo=0`, plays 1,2,4,8 → FIM_ACERTO, `pronto=1`, `acertou=1`, `errou=0`, 3 cycles after the 4th edge.
3. `modo=0`, plays 1,2,5 → FIM_ERRO after the 3rd play, `errou=1`, `db_contagem`=2. Then `iniciar` → PREPARA, and outputs clear.
4. `modo=1`, plays 1 | 1,2 | 1,2,4 | 1,2,4,8 → `rodada` steps 0→3, then `acertou=1`. A wrong play 3 in round 1 → `errou=1`, `db_rodada`=1.
5. No play for 20 cycles in ESPERA → `timeout=1`, `errou=1`. A play at cycle 19 → no timeout, and the counter restarts.
6. `jogar` held high for 10 cycles → one play only. A `jogar` edge during COMPARA is ignored. `escreve` during ESPERA → `mem` unchanged.
